// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] SZ_B = 4'b0001;
    localparam logic [3:0] SZ_H = 4'b0010;
    localparam logic [3:0] SZ_W = 4'b0100;
    localparam logic [3:0] SZ_D = 4'b1000;

    // Byte count of a one-hot size code; 0 flags an illegal encoding.
    function automatic logic [3:0] size_bytes(input logic [3:0] size);
        case (size)
            SZ_B:    size_bytes = 4'd1;
            SZ_H:    size_bytes = 4'd2;
            SZ_W:    size_bytes = 4'd4;
            SZ_D:    size_bytes = 4'd8;
            default: size_bytes = 4'd0;
        endcase
    endfunction

    function automatic logic [7:0] byte_mask(input logic [3:0] size, input logic [2:0] offset);
        case (size)
            SZ_B:    byte_mask = 8'b0000_0001 << offset;
            SZ_H:    byte_mask = 8'b0000_0011 << offset;
            SZ_W:    byte_mask = 8'b0000_1111 << offset;
            SZ_D:    byte_mask = 8'b1111_1111;
            default: byte_mask = 8'b0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_storage.sv
// Word-organised storage with per-byte write enables and an asynchronous full-word read.
module dmem_storage #(
    parameter int DEPTH_WORDS = 128,
    parameter int AW          = 7
) (
    input  logic          clk,
    input  logic [7:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] mem_r [DEPTH_WORDS];

    // Byte-lane write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (be[i]) begin
                mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store responder: request handshake, programmable wait, held response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [3:0]  req_size,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [64:0] LIMIT = 65'(8 * DEPTH_WORDS);
    localparam logic [3:0]  LAT   = 4'(LATENCY);

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic [63:0] rsp_rdata_r;
    logic        rsp_err_r;

    logic        lat_write_r;
    logic [63:0] lat_addr_r;
    logic [3:0]  lat_size_r;
    logic [63:0] lat_wdata_r;

    logic        op_write_s;
    logic [63:0] op_addr_s;
    logic [3:0]  op_size_s;
    logic [63:0] op_wdata_s;
    logic [3:0]  op_bytes_s;
    logic [64:0] op_end_s;
    logic        op_err_s;
    logic        enter_resp_s;
    logic        commit_s;
    logic [7:0]  be_s;
    logic [63:0] wdata_lane_s;
    logic [63:0] word_s;
    logic [63:0] shifted_s;
    logic [63:0] lane_bits_s;
    logic [63:0] load_data_s;

    // Operand select and error/lane computation; with zero latency RESP is entered
    // on the handshake edge itself, so the live request is used in IDLE.
    always_comb begin
        if (state_r == IDLE) begin
            op_write_s = req_write;
            op_addr_s  = req_addr;
            op_size_s  = req_size;
            op_wdata_s = req_wdata;
        end else begin
            op_write_s = lat_write_r;
            op_addr_s  = lat_addr_r;
            op_size_s  = lat_size_r;
            op_wdata_s = lat_wdata_r;
        end

        op_bytes_s = size_bytes(op_size_s);
        op_end_s   = {1'b0, op_addr_s} + {61'd0, op_bytes_s};
        op_err_s   = (op_bytes_s == 4'd0)
                  || ((op_addr_s[2:0] & 3'(op_bytes_s - 4'd1)) != 3'd0)
                  || (op_end_s > LIMIT);

        case (state_r)
            IDLE:    enter_resp_s = req_valid && req_ready_r && (LAT == 4'd0);
            WAIT:    enter_resp_s = (cnt_r == 4'd1);
            default: enter_resp_s = 1'b0;
        endcase

        commit_s     = reset && enter_resp_s && op_write_s && !op_err_s;
        be_s         = commit_s ? byte_mask(op_size_s, op_addr_s[2:0]) : 8'h00;
        wdata_lane_s = op_wdata_s << {op_addr_s[2:0], 3'b000};

        shifted_s   = word_s >> {op_addr_s[2:0], 3'b000};
        lane_bits_s = 64'd0;
        for (int i = 0; i < 8; i++) begin
            lane_bits_s[8*i +: 8] = {8{4'(i) < op_bytes_s}};
        end
        if (op_write_s || op_err_s) begin
            load_data_s = 64'd0;
        end else begin
            load_data_s = shifted_s & lane_bits_s;
        end
    end

    dmem_storage #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_storage (
        .clk   (clk),
        .be    (be_s),
        .addr  (op_addr_s[AW+2:3]),
        .wdata (wdata_lane_s),
        .rdata (word_s)
    );

    // Request capture at the handshake; no reset needed since fields are only used after capture.
    always_ff @(posedge clk) begin
        if (state_r == IDLE && req_valid && req_ready_r) begin
            lat_write_r <= req_write;
            lat_addr_r  <= req_addr;
            lat_size_r  <= req_size;
            lat_wdata_r <= req_wdata;
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 64'd0;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid && req_ready_r) begin
                        req_ready_r <= 1'b0;
                        if (LAT == 4'd0) begin
                            state_r     <= RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_rdata_r <= load_data_s;
                            rsp_err_r   <= op_err_s;
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= LAT;
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_r == 4'd1) begin
                        state_r     <= RESP;
                        cnt_r       <= 4'd0;
                        rsp_valid_r <= 1'b1;
                        rsp_rdata_r <= load_data_s;
                        rsp_err_r   <= op_err_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_r     <= IDLE;
                        rsp_valid_r <= 1'b0;
                        rsp_rdata_r <= 64'd0;
                        rsp_err_r   <= 1'b0;
                        req_ready_r <= 1'b1;
                    end else begin
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= 4'd0;
                    req_ready_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    rsp_rdata_r <= 64'd0;
                    rsp_err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule
